// File: rtl/imm_builder_pkg.sv
// imm_builder_pkg
//   Shared definitions for the immediate builder slice: selector
//   encodings driven by the decoder and the prefix FSM state encoding.
//   No ports; imported with import imm_builder_pkg::*.
package imm_builder_pkg;

    // Immediate selector codes; any code not listed behaves as NONE.
    typedef enum logic [2:0] {
        IMMSEL_NONE   = 3'b000,
        IMMSEL_I_TYPE = 3'b001,
        IMMSEL_J_TYPE = 3'b010,
        IMMSEL_PREFIX = 3'b100
    } imm_sel_e;

    // IDLE: no prefix held; PFX: at least one prefix payload accumulated.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PFX  = 1'b1
    } pfx_state_e;

endpackage

// File: rtl/imm_builder_if.sv
// imm_builder_if
//   Decoder-side request and consumer-side result handshake of the
//   immediate builder.
//   Signals:
//     i_valid / o_ready          instruction handshake (decoder -> block)
//     i_immRaw, i_immSel, i_zext raw field, selector, zero-extend flag
//     i_flush                    pipeline flush
//     o_valid / i_ready          result handshake (block -> consumer)
//     o_imm_ext                  extended immediate
//     o_pfx_err                  one-cycle prefix overflow pulse
//   Modports: slave (the builder), master (the decoder/consumer side).
interface imm_builder_if #(
    parameter int unsigned DATA_WIDTH    = 36,
    parameter int unsigned IMM_MAX_WIDTH = 14,
    parameter int unsigned SELECT_WIDTH  = 3
);
    logic                     i_valid;
    logic                     o_ready;
    logic [IMM_MAX_WIDTH-1:0] i_immRaw;
    logic [SELECT_WIDTH-1:0]  i_immSel;
    logic                     i_zext;
    logic                     i_flush;
    logic                     o_valid;
    logic                     i_ready;
    logic [DATA_WIDTH-1:0]    o_imm_ext;
    logic                     o_pfx_err;

    modport slave (
        input  i_valid, i_immRaw, i_immSel, i_zext, i_flush, i_ready,
        output o_ready, o_valid, o_imm_ext, o_pfx_err
    );

    modport master (
        output i_valid, i_immRaw, i_immSel, i_zext, i_flush, i_ready,
        input  o_ready, o_valid, o_imm_ext, o_pfx_err
    );
endinterface

// File: rtl/imm_field_ext.sv
// imm_field_ext
//   Combinational extension of a right-aligned value of run-time width
//   to DATA_WIDTH bits. Values at least DATA_WIDTH wide are truncated.
//   Ports:
//     value_i  right-aligned value (bits at and above width_i must be 0)
//     width_i  number of meaningful bits in value_i (>= 1)
//     zext_i   1 = zero-extend, 0 = sign-extend from bit width_i-1
//     ext_o    extended result
module imm_field_ext #(
    parameter int unsigned VAL_W      = 42,
    parameter int unsigned WID_W      = 6,
    parameter int unsigned DATA_WIDTH = 36
) (
    input  logic [VAL_W-1:0]      value_i,
    input  logic [WID_W-1:0]      width_i,
    input  logic                  zext_i,
    output logic [DATA_WIDTH-1:0] ext_o
);
    logic                  fill;
    logic [DATA_WIDTH-1:0] keep;

    always_comb begin
        // MSB of the value picked out with a one-hot mask.
        fill = ~zext_i & (|(value_i & (VAL_W'(1) << (width_i - WID_W'(1)))));
        // Shifting by >= DATA_WIDTH yields all-ones keep, i.e. truncation.
        keep = ~({DATA_WIDTH{1'b1}} << width_i);
        ext_o = (DATA_WIDTH'(value_i) & keep) | ({DATA_WIDTH{fill}} & ~keep);
    end
endmodule

// File: rtl/imm_builder.sv
// imm_builder
//   Pipelined immediate extender with prefix accumulation and a
//   registered valid/ready output stage.
//   Ports:
//     i_clk  clock, all state on rising edge
//     i_rst  synchronous active-high reset
//     bus    imm_builder_if.slave (instruction in, result out)
//   Configuration: define IMM_PREFIX_EN to build the prefix accumulator,
//   PFX state and o_pfx_err; otherwise PREFIX acts as NONE and
//   o_pfx_err is tied low.
module imm_builder
    import imm_builder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 36,
    parameter int unsigned IMM_MAX_WIDTH = 14,
    parameter int unsigned I_IMM_WIDTH   = 8,
    parameter int unsigned J_IMM_WIDTH   = 14,
    parameter int unsigned MAX_PREFIX    = 2,
    parameter int unsigned SELECT_WIDTH  = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    imm_builder_if.slave bus
);
    localparam int unsigned ACC_W = MAX_PREFIX * IMM_MAX_WIDTH;
    localparam int unsigned VAL_W = ACC_W + IMM_MAX_WIDTH;
    localparam int unsigned WID_W = $clog2(VAL_W + 1);
    localparam int unsigned CNT_W = $clog2(MAX_PREFIX + 1);

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] imm_q, imm_d;
    logic                  accept, is_i, is_j, take_data;
    logic [VAL_W-1:0]      field, comb_val;
    logic [WID_W-1:0]      fwidth, comb_wid;
    logic [DATA_WIDTH-1:0] ext_val;

    assign bus.o_ready   = !valid_q || bus.i_ready;
    assign bus.o_valid   = valid_q;
    assign bus.o_imm_ext = imm_q;

    assign accept = bus.i_valid && bus.o_ready;
    assign is_i   = (bus.i_immSel == SELECT_WIDTH'(IMMSEL_I_TYPE));
    assign is_j   = (bus.i_immSel == SELECT_WIDTH'(IMMSEL_J_TYPE));

    always_comb begin
        if (is_j) begin
            field  = VAL_W'(bus.i_immRaw[J_IMM_WIDTH-1:0]);
            fwidth = WID_W'(J_IMM_WIDTH);
        end else begin
            field  = VAL_W'(bus.i_immRaw[I_IMM_WIDTH-1:0]);
            fwidth = WID_W'(I_IMM_WIDTH);
        end
    end

`ifdef IMM_PREFIX_EN
    pfx_state_e       state_q, state_d;
    logic [ACC_W-1:0] pfx_acc_q, pfx_acc_d;
    logic [CNT_W-1:0] pfx_cnt_q, pfx_cnt_d;
    logic             pfx_err_q, pfx_err_d;
    logic [ACC_W-1:0] held;
    logic             is_pfx;

    assign is_pfx        = (bus.i_immSel == SELECT_WIDTH'(IMMSEL_PREFIX));
    assign take_data     = accept && !is_pfx;
    assign bus.o_pfx_err = pfx_err_q;

    always_comb begin
        held = '0;
        if (state_q == ST_PFX) begin
            held = pfx_acc_q & ~({ACC_W{1'b1}} << (32'(pfx_cnt_q) * IMM_MAX_WIDTH));
        end
        // Held prefixes sit directly above the instruction's own field.
        comb_val = (VAL_W'(held) << fwidth) | field;
        comb_wid = fwidth + WID_W'(32'(pfx_cnt_q) * IMM_MAX_WIDTH);
    end

    always_comb begin
        pfx_acc_d = pfx_acc_q;
        pfx_cnt_d = pfx_cnt_q;
        pfx_err_d = 1'b0;
        if (bus.i_flush) begin
            pfx_acc_d = '0;
            pfx_cnt_d = '0;
        end else if (accept) begin
            if (is_pfx) begin
                if (32'(pfx_cnt_q) < MAX_PREFIX) begin
                    pfx_acc_d = (pfx_acc_q << IMM_MAX_WIDTH) | ACC_W'(bus.i_immRaw);
                    pfx_cnt_d = pfx_cnt_q + CNT_W'(1);
                end else begin
                    pfx_err_d = 1'b1;
                end
            end else begin
                pfx_acc_d = '0;
                pfx_cnt_d = '0;
            end
        end
        state_d = (pfx_cnt_d != '0) ? ST_PFX : ST_IDLE;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            pfx_acc_q <= '0;
            pfx_cnt_q <= '0;
            pfx_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pfx_acc_q <= pfx_acc_d;
            pfx_cnt_q <= pfx_cnt_d;
            pfx_err_q <= pfx_err_d;
        end
    end
`else
    assign take_data     = accept;
    assign comb_val      = field;
    assign comb_wid      = fwidth;
    assign bus.o_pfx_err = 1'b0;
`endif

    imm_field_ext #(
        .VAL_W      (VAL_W),
        .WID_W      (WID_W),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ext (
        .value_i (comb_val),
        .width_i (comb_wid),
        .zext_i  (bus.i_zext),
        .ext_o   (ext_val)
    );

    always_comb begin
        valid_d = valid_q;
        imm_d   = imm_q;
        if (valid_q && bus.i_ready) begin
            valid_d = 1'b0;
        end
        if (bus.i_flush) begin
            valid_d = 1'b0;
        end else if (take_data) begin
            valid_d = 1'b1;
            imm_d   = (is_i || is_j) ? ext_val : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            imm_q   <= '0;
        end else begin
            valid_q <= valid_d;
            imm_q   <= imm_d;
        end
    end
endmodule

// File: tb/tb_imm_builder.sv
// tb_imm_builder
//   Self-checking bench for imm_builder: directed steps followed by
//   random traffic, compared against a behavioural model that keeps held
//   prefixes in a queue and builds results with plain arithmetic.
module tb_imm_builder;
    localparam int unsigned DW  = 36;
    localparam int unsigned IMW = 14;
    localparam int unsigned IW  = 8;
    localparam int unsigned JW  = 14;
    localparam int unsigned MAXP = 2;
    localparam int unsigned SW  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imm_builder_if #(.DATA_WIDTH(DW), .IMM_MAX_WIDTH(IMW), .SELECT_WIDTH(SW)) bus ();

    imm_builder #(
        .DATA_WIDTH    (DW),
        .IMM_MAX_WIDTH (IMW),
        .I_IMM_WIDTH   (IW),
        .J_IMM_WIDTH   (JW),
        .MAX_PREFIX    (MAXP),
        .SELECT_WIDTH  (SW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // Model state
    logic [63:0] m_pfx[$];
    bit          m_valid;
    logic [63:0] m_imm;
    bit          m_err;

`ifdef IMM_PREFIX_EN
    localparam bit PFX_EN = 1'b1;
`else
    localparam bit PFX_EN = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pfx.delete();
        m_valid = 1'b0;
        m_imm   = '0;
        m_err   = 1'b0;
    endtask

    // Value of the instruction given the held prefixes, oldest prefix highest.
    function automatic logic [63:0] build(input int w, input logic [13:0] raw, input bit z);
        logic [63:0] c;
        int          n;
        int          wc;
        n  = m_pfx.size();
        c  = 64'(raw) & ((64'd1 << w) - 1);
        for (int k = 0; k < n; k++) begin
            c = c | (m_pfx[k] << (w + (n - 1 - k) * int'(IMW)));
        end
        wc = w + n * int'(IMW);
        if (wc < int'(DW) && !z && c[wc-1]) begin
            c = c | ~((64'd1 << wc) - 1);
        end
        return c & ((64'd1 << DW) - 1);
    endfunction

    task automatic model_step(input bit v, input logic [2:0] sel, input logic [13:0] raw,
                              input bit z, input bit fl, input bit rdy);
        bit acc;
        acc   = v && (!m_valid || rdy);
        m_err = 1'b0;
        if (m_valid && rdy) m_valid = 1'b0;
        if (fl) begin
            m_pfx.delete();
            m_valid = 1'b0;
        end else if (acc) begin
            if (sel == 3'b100 && PFX_EN) begin
                if (m_pfx.size() < int'(MAXP)) m_pfx.push_back(64'(raw));
                else m_err = 1'b1;
            end else begin
                if (sel == 3'b001)      m_imm = build(int'(IW), raw, z);
                else if (sel == 3'b010) m_imm = build(int'(JW), raw, z);
                else                    m_imm = '0;
                m_valid = 1'b1;
                m_pfx.delete();
            end
        end
    endtask

    task automatic check_outputs(input string where);
        chk({where, "_o_valid"},   64'(bus.o_valid),   64'(m_valid));
        chk({where, "_o_imm_ext"}, 64'(bus.o_imm_ext), m_imm);
        chk({where, "_o_pfx_err"}, 64'(bus.o_pfx_err), 64'(m_err));
    endtask

    // Called #1 after a rising edge; applies inputs, checks o_ready,
    // clocks once and checks the registered outputs.
    task automatic step(input bit v, input logic [2:0] sel, input logic [13:0] raw,
                        input bit z, input bit fl, input bit rdy, input string tag);
        bus.i_valid  = v;
        bus.i_immSel = sel;
        bus.i_immRaw = raw;
        bus.i_zext   = z;
        bus.i_flush  = fl;
        bus.i_ready  = rdy;
        #1;
        chk({tag, "_o_ready"}, 64'(bus.o_ready), 64'(!m_valid || rdy));
        model_step(v, sel, raw, z, fl, rdy);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst          = 1'b1;
        bus.i_valid  = 1'b0;
        bus.i_immSel = '0;
        bus.i_immRaw = '0;
        bus.i_zext   = 1'b0;
        bus.i_flush  = 1'b0;
        bus.i_ready  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        check_outputs(tag);
    endtask

    logic [2:0] sel_pool[8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b100, 3'b011, 3'b101, 3'b111};

    initial begin
        model_reset();
        do_reset("reset");
        chk("reset_o_ready", 64'(bus.o_ready), 64'd1);

        // Plain sign / zero extension of an I-type field.
        step(1, 3'b001, 14'h0FF, 0, 0, 1, "tp1_sext");
        chk("tp1_sext_const", 64'(bus.o_imm_ext), 64'hF_FFFF_FFFF);
        step(1, 3'b001, 14'h0FF, 1, 0, 1, "tp1_zext");
        chk("tp1_zext_const", 64'(bus.o_imm_ext), 64'h0_0000_00FF);

        // One prefix then I-type.
        step(1, 3'b100, 14'h0001, 0, 0, 1, "tp2_pfx");
        step(1, 3'b001, 14'h0034, 0, 0, 1, "tp2_i");
`ifdef IMM_PREFIX_EN
        chk("tp2_const", 64'(bus.o_imm_ext), 64'h0_0000_0134);
`endif

        // Sign bit supplied by the prefix.
        step(1, 3'b100, 14'h2000, 0, 0, 1, "tp3_pfx");
        step(1, 3'b001, 14'h0000, 0, 0, 1, "tp3_i");
`ifdef IMM_PREFIX_EN
        chk("tp3_const", 64'(bus.o_imm_ext), 64'hF_FFE0_0000);
`endif

        // 42-bit combined value truncated.
        step(1, 3'b100, 14'h3FFF, 0, 0, 1, "tp4_pfx0");
        step(1, 3'b100, 14'h3FFF, 0, 0, 1, "tp4_pfx1");
        step(1, 3'b010, 14'h3FFF, 0, 0, 1, "tp4_j");
`ifdef IMM_PREFIX_EN
        chk("tp4_const", 64'(bus.o_imm_ext), 64'hF_FFFF_FFFF);
`endif

        // Prefix overflow: third is dropped with a single error pulse.
        step(1, 3'b100, 14'h0AAA, 1, 0, 1, "tp5_pfx0");
        step(1, 3'b100, 14'h1555, 1, 0, 1, "tp5_pfx1");
        step(1, 3'b100, 14'h3FFF, 1, 0, 1, "tp5_pfx2");
`ifdef IMM_PREFIX_EN
        chk("tp5_err_pulse", 64'(bus.o_pfx_err), 64'd1);
`endif
        step(1, 3'b010, 14'h0005, 1, 0, 1, "tp5_j");
`ifdef IMM_PREFIX_EN
        chk("tp5_const", 64'(bus.o_imm_ext),
            ((64'hAAA << 28) | (64'h1555 << 14) | 64'h5) & 64'hF_FFFF_FFFF);
`endif

        // Backpressure for three cycles, then flush with a new instruction.
        step(1, 3'b001, 14'h0012, 1, 0, 0, "tp6_load");
        for (int i = 0; i < 3; i++) begin
            step(1, 3'b010, 14'h1234, 0, 0, 0, "tp6_hold");
        end
        step(1, 3'b001, 14'h0077, 0, 1, 0, "tp6_flush");
        chk("tp6_flush_valid", 64'(bus.o_valid), 64'd0);

        // Random traffic, with one reset in the middle of a sequence.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset("mid_reset");
            step(($urandom_range(0, 3) != 0),
                 sel_pool[$urandom_range(0, 7)],
                 14'($urandom),
                 1'($urandom),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0),
                 "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
